// File: rtl/mux_scan_pkg.sv
// +------------------------------------------------------------------+
// | mux_scan_pkg : shared constants and helpers for mux_scan_sel      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Next channel index in scan order, wrapping the last channel back to 0.
  function automatic int wrap_inc(input int cur, input int channels);
    return (cur >= channels - 1) ? 0 : cur + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_sel_scan_timer.sv
// +------------------------------------------------------------------+
// | scan_timer : dwell counter producing a terminal-count tick        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module scan_timer #(
  parameter int DWELL = 25000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = enable && (count_q == C_LAST);

  // clear wins over enable; with neither asserted the count is frozen.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sel.sv
// +------------------------------------------------------------------+
// | mux_scan_sel : N-channel selector, manual or timed auto-scan      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 25000000
) (
  input  logic                              Clock,
  input  logic                              Resetn,
  input  logic                              mode,
  input  logic                              hold,
  input  logic [$clog2(CHANNELS)-1:0]       sel_in,
  input  logic [CHANNELS*WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]                  data_out,
  output logic [$clog2(CHANNELS)-1:0]       sel_out,
  output logic                              changed
);

  localparam int SEL_W = $clog2(CHANNELS);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             changed_q;
  logic             changed_d;

  logic             timer_en;
  logic             timer_clr;
  logic             tick;
  logic             req_in_range;
  logic [WIDTH-1:0] chan [CHANNELS];

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_chan
      assign chan[k] = data_in[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Manual mode parks the counter at 0 so a later switch to scan starts fresh.
  assign timer_en  = (mode == MODE_SCAN)   && !hold;
  assign timer_clr = (mode == MODE_MANUAL) && !hold;

  scan_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .enable (timer_en),
    .clear  (timer_clr),
    .tick   (tick)
  );

  assign req_in_range = ({1'b0, sel_in} < (SEL_W + 1)'(CHANNELS));

  always_comb begin
    sel_d = sel_q;
    if (!hold) begin
      if (mode == MODE_SCAN) begin
        if (tick) begin
          sel_d = SEL_W'(wrap_inc(int'(sel_q), CHANNELS));
        end
      end else if (req_in_range) begin
        sel_d = sel_in;
      end
    end
  end

  // Data follows the selection being registered, so both move on one edge.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_d == SEL_W'(i)) begin
        data_d = chan[i];
      end
    end
  end

  assign changed_d = (sel_d != sel_q);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel_q     <= '0;
      data_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      data_q    <= data_d;
      changed_q <= changed_d;
    end
  end

  assign sel_out  = sel_q;
  assign data_out = data_q;
  assign changed  = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: a 4x2 instance and a 3x4 instance (out-of-range requests), DWELL=3.
`default_nettype none

module tb_mux_scan_sel;

  localparam int DW = 3;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;

  logic        mode = 1'b0, hold = 1'b0;
  logic [1:0]  sel_in = '0;
  logic [7:0]  data_in = '0;
  logic [1:0]  data_out;
  logic [1:0]  sel_out;
  logic        changed;

  logic        mode_b = 1'b0, hold_b = 1'b0;
  logic [1:0]  sel_in_b = '0;
  logic [11:0] data_in_b = '0;
  logic [3:0]  data_out_b;
  logic [1:0]  sel_out_b;
  logic        changed_b;

  always #5 Clock = ~Clock;

  mux_scan_sel #(.WIDTH(2), .CHANNELS(4), .DWELL(DW)) dut (
    .Clock(Clock), .Resetn(Resetn), .mode(mode), .hold(hold), .sel_in(sel_in),
    .data_in(data_in), .data_out(data_out), .sel_out(sel_out), .changed(changed));

  mux_scan_sel #(.WIDTH(4), .CHANNELS(3), .DWELL(DW)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .mode(mode_b), .hold(hold_b), .sel_in(sel_in_b),
    .data_in(data_in_b), .data_out(data_out_b), .sel_out(sel_out_b), .changed(changed_b));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sel;
    int cnt;
    int data;
    int chg;
  } mstate_t;

  mstate_t ma, mb;

  // Behavioural model: one clock edge of the selector, straight from its rules.
  function automatic mstate_t mstep(mstate_t s, int ch, int w, bit m, bit h, int req, longint d);
    mstate_t n = s;
    int nsel = s.sel;
    if (!h) begin
      if (m) begin
        if (s.cnt == DW - 1) begin
          n.cnt = 0;
          nsel  = (s.sel + 1) % ch;
        end else begin
          n.cnt = s.cnt + 1;
        end
      end else begin
        n.cnt = 0;
        if (req < ch) nsel = req;
      end
    end
    n.chg  = (nsel != s.sel) ? 1 : 0;
    n.sel  = nsel;
    n.data = int'((d >> (nsel * w)) & ((64'd1 << w) - 1));
    return n;
  endfunction

  function automatic mstate_t mreset();
    mstate_t z;
    z.sel = 0; z.cnt = 0; z.data = 0; z.chg = 0;
    return z;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("a.sel",  32'(sel_out),    32'(ma.sel));
    chk("a.data", 32'(data_out),   32'(ma.data));
    chk("a.chg",  32'(changed),    32'(ma.chg));
    chk("b.sel",  32'(sel_out_b),  32'(mb.sel));
    chk("b.data", 32'(data_out_b), 32'(mb.data));
    chk("b.chg",  32'(changed_b),  32'(mb.chg));
  endtask

  task automatic step();
    ma = mstep(ma, 4, 2, mode, hold, int'(sel_in), longint'(data_in));
    mb = mstep(mb, 3, 4, mode_b, hold_b, int'(sel_in_b), longint'(data_in_b));
    @(posedge Clock);
    #1;
    chk_models();
  endtask

  // Reset is applied away from the clock edge and must take effect at once.
  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    chk("rst.sel",  32'(sel_out),  32'd0);
    chk("rst.data", 32'(data_out), 32'd0);
    chk("rst.chg",  32'(changed),  32'd0);
    @(posedge Clock);
    #1;
    chk_models();
    Resetn = 1'b1;
  endtask

  typedef struct {
    logic       m;
    logic       h;
    logic [1:0] s;
    logic [7:0] d;
    int         e_sel;
    int         e_data;
    int         e_chg;
  } vec_t;

  vec_t tbl [8];
  int   scan_exp [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 2'd3, 8'hE4, 3, 3, 1};
    tbl[1] = '{1'b0, 1'b0, 2'd3, 8'hE4, 3, 3, 0};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 8'hE4, 0, 0, 1};
    tbl[3] = '{1'b0, 1'b0, 2'd1, 8'hE4, 1, 1, 1};
    tbl[4] = '{1'b0, 1'b0, 2'd2, 8'hE4, 2, 2, 1};
    tbl[5] = '{1'b0, 1'b0, 2'd2, 8'h1B, 2, 1, 0};
    tbl[6] = '{1'b0, 1'b1, 2'd0, 8'h1B, 2, 1, 0};
    tbl[7] = '{1'b0, 1'b0, 2'd3, 8'h1B, 3, 0, 1};

    ma = mreset();
    mb = mreset();
    data_in = 8'hE4;
    #2;
    chk("por.sel",  32'(sel_out),  32'd0);
    chk("por.data", 32'(data_out), 32'd0);
    chk("por.chg",  32'(changed),  32'd0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;

    step();
    chk("first.chg", 32'(changed), 32'd0);

    // Manual selection table
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].m; hold = tbl[i].h; sel_in = tbl[i].s; data_in = tbl[i].d;
      step();
      chk($sformatf("tbl%0d.sel", i),  32'(sel_out),  32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d.data", i), 32'(data_out), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d.chg", i),  32'(changed),  32'(tbl[i].e_chg));
    end

    // Scan wrap 0,1,2,3,0 with 3-cycle dwell
    sel_in = 2'd0; data_in = 8'hE4;
    step();
    chk("pre_scan.sel", 32'(sel_out), 32'd0);
    mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sel_in = 2'(i);
      step();
      chk($sformatf("scan%0d.sel", i),  32'(sel_out),  32'(scan_exp[i]));
      chk($sformatf("scan%0d.data", i), 32'(data_out), 32'(scan_exp[i]));
      chk($sformatf("scan%0d.chg", i),  32'(changed),  32'((i % 3 == 2) ? 1 : 0));
    end

    // Hold at counter==2 with live data on the current channel
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = (8'hE4 & 8'hFC) | 8'(i % 4);
      step();
      chk($sformatf("hold%0d.sel", i),  32'(sel_out),  32'd0);
      chk($sformatf("hold%0d.data", i), 32'(data_out), 32'(i % 4));
      chk($sformatf("hold%0d.chg", i),  32'(changed),  32'd0);
    end
    hold = 1'b0; data_in = 8'hE4;
    step();
    chk("release.sel", 32'(sel_out), 32'd1);
    chk("release.chg", 32'(changed), 32'd1);

    // Mode switch: scan to 2, manual to 1, scan again steps to 2 after 3 cycles
    step(); step(); step();
    chk("ms.sel2", 32'(sel_out), 32'd2);
    mode = 1'b0; sel_in = 2'd1;
    step();
    chk("ms.man.sel", 32'(sel_out), 32'd1);
    chk("ms.man.chg", 32'(changed), 32'd1);
    mode = 1'b1;
    step(); chk("ms.w1", 32'(sel_out), 32'd1);
    step(); chk("ms.w2", 32'(sel_out), 32'd1);
    step(); chk("ms.step", 32'(sel_out), 32'd2);

    // Mid-run reset with E4 on the inputs
    @(negedge Clock);
    data_in = 8'hE4;
    do_reset();

    // Out-of-range request on the 3-channel instance
    mode = 1'b0; hold = 1'b0; sel_in = 2'd0;
    data_in_b = 12'h987; mode_b = 1'b0; hold_b = 1'b0; sel_in_b = 2'd1;
    step();
    chk("oor.sel1", 32'(sel_out_b), 32'd1);
    chk("oor.dat1", 32'(data_out_b), 32'd8);
    sel_in_b = 2'd3; data_in_b = 12'hA87;
    step();
    chk("oor.sel",  32'(sel_out_b),  32'd1);
    chk("oor.data", 32'(data_out_b), 32'd8);
    chk("oor.chg",  32'(changed_b),  32'd0);
    sel_in_b = 2'd2;
    step();
    chk("oor.acc.sel",  32'(sel_out_b),  32'd2);
    chk("oor.acc.data", 32'(data_out_b), 32'd10);
    chk("oor.acc.chg",  32'(changed_b),  32'd1);

    // Randomised traffic on both instances against the model
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 3) != 0);
      hold      = 1'($urandom_range(0, 7) == 0);
      sel_in    = 2'($urandom);
      data_in   = 8'($urandom);
      mode_b    = 1'($urandom_range(0, 3) != 0);
      hold_b    = 1'($urandom_range(0, 7) == 0);
      sel_in_b  = 2'($urandom);
      data_in_b = 12'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
